// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Brief    : Run/pause/adjust sequencer and MM:SS counters for the lab
//            stopwatch. All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int SEC_MAX = 59,
    parameter int MIN_MAX = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       pause_vld,
    input  logic       reset_vld,
    input  logic       adj,
    input  logic       sel,
    output logic [6:0] min,
    output logic [5:0] sec,
    output logic       running,
    output logic       blink,
    output logic       blink_sel
);

    localparam logic [6:0] c_min_max = 7'(MIN_MAX);
    localparam logic [5:0] c_sec_max = 6'(SEC_MAX);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_ADJUST = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [6:0] r_min;
    logic [6:0] w_min_nxt;
    logic [5:0] r_sec;
    logic [5:0] w_sec_nxt;
    logic       r_running;
    logic       w_running_nxt;
    logic       r_blink;
    logic       w_blink_nxt;
    logic       r_blink_sel;
    logic       w_blink_sel_nxt;

    // Next-state and next-output decode; reset_vld outranks adj, adj outranks pause_vld.
    always_comb begin
        w_state_nxt = r_state;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;
        w_blink_nxt = 1'b0;

        if (reset_vld) begin
            w_min_nxt = '0;
            w_sec_nxt = '0;
            if (adj) begin
                w_state_nxt = ST_ADJUST;
                // Staying in ADJUST keeps the blink phase; the tick is dropped.
                if (r_state == ST_ADJUST) begin
                    w_blink_nxt = r_blink;
                end
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (adj) begin
                        w_state_nxt = ST_ADJUST;
                    end else if (pause_vld) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // The count tick is applied even when the state changes this cycle.
                    if (tick_1hz) begin
                        if (r_sec < c_sec_max) begin
                            w_sec_nxt = r_sec + 6'd1;
                        end else begin
                            w_sec_nxt = '0;
                            w_min_nxt = (r_min < c_min_max) ? r_min + 7'd1 : '0;
                        end
                    end
                    if (adj) begin
                        w_state_nxt = ST_ADJUST;
                    end else if (pause_vld) begin
                        w_state_nxt = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (adj) begin
                        w_state_nxt = ST_ADJUST;
                    end else if (pause_vld) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_ADJUST: begin
                    if (!adj) begin
                        w_state_nxt = ST_PAUSED;
                    end else begin
                        w_blink_nxt = r_blink;
                        // Each 2 Hz tick bumps the selected field without carry.
                        if (tick_2hz) begin
                            w_blink_nxt = ~r_blink;
                            if (sel) begin
                                w_sec_nxt = (r_sec < c_sec_max) ? r_sec + 6'd1 : '0;
                            end else begin
                                w_min_nxt = (r_min < c_min_max) ? r_min + 7'd1 : '0;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        w_running_nxt   = (w_state_nxt == ST_RUN);
        w_blink_sel_nxt = (w_state_nxt == ST_ADJUST) ? sel : 1'b0;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_min       <= '0;
            r_sec       <= '0;
            r_running   <= 1'b0;
            r_blink     <= 1'b0;
            r_blink_sel <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_min       <= w_min_nxt;
            r_sec       <= w_sec_nxt;
            r_running   <= w_running_nxt;
            r_blink     <= w_blink_nxt;
            r_blink_sel <= w_blink_sel_nxt;
        end
    end

    assign min       = r_min;
    assign sec       = r_sec;
    assign running   = r_running;
    assign blink     = r_blink;
    assign blink_sel = r_blink_sel;

endmodule
`default_nettype wire
